alu_issue_scheduler: RTL and testbench
======================================

Name: alu_issue_scheduler

Overview:
- Round-robin issue scheduler that shares the single pipelined ALU between NUM_REQ reservation-station issue ports.
- Each cycle it selects at most one ready RS packet and grants it. The packet is captured into a registered issue stage that drives the ALU wrapper's instruction-info input.
- Honors downstream backpressure (alu_ready) and pipeline flush. Keeps an issued-instruction counter for performance monitoring.

Parameters:
- NUM_REQ, 4, number of requesting RS issue ports (>=2)
- IDX_W, $clog2(NUM_REQ), width of the round-robin pointer
- CNT_W, 16, width of the issued-instruction counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  bit i = port i holds a ready-to-issue packet
- req_info  in  NUM_REQ*`RS_WIDTH  packed packets; port i at bits [i*`RS_WIDTH +: `RS_WIDTH]
- req_grant  out  NUM_REQ  one-hot or zero; combinational; bit i = port i's packet is accepted this cycle
- alu_ready  in  1  ALU side accepts the issue register this cycle
- flush  in  1  squash the in-flight issue slot and block grants this cycle
- issue_valid  out  1  issue register holds a valid packet
- issue_info  out  `RS_WIDTH  packet presented to the ALU wrapper
- issue_count  out  CNT_W  number of packets moved into the issue register, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst low, asynchronous):
  - issue_valid=0, issue_info=0, rr_ptr=0, issue_count=0.
  - req_grant reads 0 while reset is asserted.
- Slot availability:
  - can_accept = !flush && (!issue_valid || alu_ready).
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending, wrapping at NUM_REQ-1 to 0.
  - The first set bit wins.
  - req_grant = onehot(winner) when can_accept and any req_valid is set; otherwise 0.
- Requester rule:
  - Hold req_valid and req_info stable until granted.
  - Dropping req_valid before grant is legal (withdrawal). No grant is made for a withdrawn port.
- On grant of index k at cycle T:
  - issue_info <= req_info[k], issue_valid <= 1, rr_ptr <= (k+1) mod NUM_REQ, issue_count <= issue_count+1.
  - Latency: grant at T, packet visible on issue_info at T+1.
- No grant, and issue_valid && alu_ready:
  - issue_valid <= 0. issue_info holds its last value (don't-care when invalid).
- No grant, and issue_valid && !alu_ready:
  - Issue register holds, rr_ptr holds.
- Simultaneous drain and fill (issue_valid && alu_ready && grant):
  - New packet loads; issue_valid stays 1.
  - Full throughput of 1 packet/cycle.
- Flush:
  - Next-cycle issue_valid=0. req_grant=0 during the flush cycle.
  - rr_ptr and issue_count unchanged. Flush overrides alu_ready and any request.
- Fairness:
  - With alu_ready held 1, a continuously valid port is granted within NUM_REQ cycles.
- Pointer:
  - Only advances on grant. Never advances past a port that did not win.
- Counter:
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation:
  - Immediate clear of every state bit; any in-flight packet is lost.

Decomposition:
- Shared constants header (already included by the ALU wrapper):
  - `RS_WIDTH and the RS field macros.
  - New macros ISSUE_CNT_W default 16 and ALU_NUM_REQ default 4, consumed as parameter defaults.
- Sub-module rr_arbiter(NUM_REQ):
  - Combinational priority search from a base pointer; outputs onehot grant, winner index, any_valid.
  - Reusable for future functional units.
- Registered issue stage, rr_ptr and counter live in the top module.

Test Plan:
- Reset and single request:
  - Stimulus: rst low 3 cycles, release; req_valid=4'b0100 with req_info[2] = 0xA5 pattern; alu_ready=1.
  - Response: req_grant=4'b0100 same cycle; issue_valid=1 and issue_info=pattern next cycle; rr_ptr=3; issue_count=1.
- Round-robin fairness:
  - Stimulus: req_valid=4'b1111 held, alu_ready=1.
  - Response: grants 0,1,2,3,0,1 on consecutive cycles; issue_valid stays 1 throughout.
- Backpressure:
  - Stimulus: issue_valid=1, alu_ready=0 for 3 cycles, req_valid=4'b0011.
  - Response: req_grant=0 all 3 cycles; issue_info unchanged. When alu_ready=1, the grant goes to the port at rr_ptr and the register reloads in the same cycle.
- Flush with requests:
  - Stimulus: flush=1 for 1 cycle with req_valid=4'b1000 and issue_valid=1.
  - Response: req_grant=0; next cycle issue_valid=0; rr_ptr and issue_count unchanged; the next cycle then grants port 3.
- Pointer wrap and withdrawal:
  - Stimulus: rr_ptr=3, req_valid=4'b1001 → port 3 granted, rr_ptr=0; then port 0 drops valid before its turn with req_valid=4'b0010.
  - Response: port 1 granted; rr_ptr=2.
- Async reset mid-stream and counter wrap:
  - Stimulus: assert rst low between clock edges while issue_valid=1.
  - Response: issue_valid, issue_count and rr_ptr read 0 before the next edge.
  - Separately, with CNT_W=4, 17 grants → issue_count=1.

Source files
------------

// File: rtl/alu_issue_scheduler_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_scheduler_pkg
// Brief    : Shared RS packet width, scheduler parameter defaults and a
//            round-robin index helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef RS_WIDTH
`define RS_WIDTH 32
`endif
`ifndef RS_OPCODE_LSB
`define RS_OPCODE_LSB 0
`endif
`ifndef RS_OPCODE_W
`define RS_OPCODE_W 6
`endif
`ifndef ISSUE_CNT_W
`define ISSUE_CNT_W 16
`endif
`ifndef ALU_NUM_REQ
`define ALU_NUM_REQ 4
`endif

package alu_issue_scheduler_pkg;

  localparam int C_RS_W = `RS_WIDTH;

  typedef logic [C_RS_W-1:0] rs_packet_t;

  // Fold an index that overshot the port count by less than n back into range.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_scheduler_arb.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational round-robin priority search starting at base_ptr,
//            ascending and wrapping. Reusable for other functional units.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import alu_issue_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   base_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int               w_idx;
  logic [IDX_W-1:0] w_sel;
  logic             w_found;

  // First set request at or after base_ptr (wrapping) wins.
  always_comb begin
    grant     = '0;
    winner    = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    w_sel     = '0;
    any_valid = |req_valid;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = rr_wrap(int'(base_ptr) + off, NUM_REQ);
      w_sel = IDX_W'(w_idx);
      if (!w_found && req_valid[w_sel]) begin
        w_found      = 1'b1;
        grant[w_sel] = 1'b1;
        winner       = w_sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_scheduler.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_scheduler
// Brief    : Round-robin issue scheduler sharing one pipelined ALU between
//            NUM_REQ RS issue ports, with a registered issue stage, flush,
//            backpressure and an issued-instruction counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int NUM_REQ = `ALU_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = `ISSUE_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*`RS_WIDTH-1:0] req_info,
  output logic [NUM_REQ-1:0]           req_grant,
  input  logic                         alu_ready,
  input  logic                         flush,
  output logic                         issue_valid,
  output logic [`RS_WIDTH-1:0]         issue_info,
  output logic [CNT_W-1:0]             issue_count
);

  logic             r_issue_valid;
  rs_packet_t       r_issue_info;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_issue_count;

  logic [NUM_REQ-1:0] w_arb_grant;
  logic [IDX_W-1:0]   w_winner;
  logic               w_any_valid;
  logic               w_can_accept;
  logic               w_do_grant;
  logic [IDX_W-1:0]   w_next_ptr;
  rs_packet_t         w_sel_info;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_valid (req_valid),
    .base_ptr  (r_rr_ptr),
    .grant     (w_arb_grant),
    .winner    (w_winner),
    .any_valid (w_any_valid)
  );

  // Slot is free when not flushing and either empty or draining this cycle;
  // grants are also suppressed while reset is held so nothing is promised.
  always_comb begin
    w_can_accept = !flush && (!r_issue_valid || alu_ready);
    w_do_grant   = rst && w_can_accept && w_any_valid;
    req_grant    = w_do_grant ? w_arb_grant : '0;
    w_next_ptr   = IDX_W'(rr_wrap(int'(w_winner) + 1, NUM_REQ));
    w_sel_info   = req_info[int'(w_winner)*C_RS_W +: C_RS_W];
  end

  // Issue register, round-robin pointer and issued-packet counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_issue_valid <= 1'b0;
      r_issue_info  <= '0;
      r_rr_ptr      <= '0;
      r_issue_count <= '0;
    end else if (w_do_grant) begin
      r_issue_valid <= 1'b1;
      r_issue_info  <= w_sel_info;
      r_rr_ptr      <= w_next_ptr;
      r_issue_count <= r_issue_count + CNT_W'(1);
    end else if (flush || (r_issue_valid && alu_ready)) begin
      r_issue_valid <= 1'b0;
    end
  end

  assign issue_valid = r_issue_valid;
  assign issue_info  = r_issue_info;
  assign issue_count = r_issue_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_scheduler.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_issue_scheduler
// Brief    : Directed self-checking bench for alu_issue_scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [31:0]  info [4];
  logic [127:0] req_info;
  logic [3:0]   req_grant;
  logic         alu_ready;
  logic         flush;
  logic         issue_valid;
  logic [31:0]  issue_info;
  logic [15:0]  issue_count;

  logic [3:0]   req_valid4;
  logic [127:0] req_info4;
  logic [3:0]   req_grant4;
  logic         alu_ready4;
  logic         flush4;
  logic         issue_valid4;
  logic [31:0]  issue_info4;
  logic [3:0]   issue_count4;

  int n_checks = 0;
  int n_fail   = 0;

  assign req_info  = {info[3], info[2], info[1], info[0]};
  assign req_info4 = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};

  always #5 clk = ~clk;

  alu_issue_scheduler #(.NUM_REQ(4), .CNT_W(16)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_info    (req_info),
    .req_grant   (req_grant),
    .alu_ready   (alu_ready),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_info  (issue_info),
    .issue_count (issue_count)
  );

  alu_issue_scheduler #(.NUM_REQ(4), .CNT_W(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid4),
    .req_info    (req_info4),
    .req_grant   (req_grant4),
    .alu_ready   (alu_ready4),
    .flush       (flush4),
    .issue_valid (issue_valid4),
    .issue_info  (issue_info4),
    .issue_count (issue_count4)
  );

  task automatic test_reset();
    rst = 1'b0; req_valid = 4'b1111; alu_ready = 1'b1; flush = 1'b0;
    req_valid4 = 4'b0000; alu_ready4 = 1'b1; flush4 = 1'b0;
    for (int i = 0; i < 4; i++) info[i] = 32'h1000_0000 + i;
    #1;
    n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", req_grant); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", issue_valid); end
    n_checks++; if (issue_info !== 32'h0) begin n_fail++; $display("FAIL reset_info: got %h expected 0", issue_info); end
    n_checks++; if (issue_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", issue_count); end
    n_checks++; if (u_dut.r_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d expected 0", u_dut.r_rr_ptr); end
    n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant_held: got %b expected 0000", req_grant); end
    req_valid = 4'b0000;
    rst = 1'b1;
  endtask

  task automatic test_single();
    info[2] = 32'hA5A5_A5A5;
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b expected 0100", req_grant); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", issue_valid); end
    n_checks++; if (issue_info !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL single_info: got %h expected a5a5a5a5", issue_info); end
    n_checks++; if (u_dut.r_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL single_ptr: got %0d expected 3", u_dut.r_rr_ptr); end
    n_checks++; if (issue_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", issue_count); end
    #1;
    n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL idle_grant: got %b expected 0000", req_grant); end
    @(posedge clk); #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b expected 0", issue_valid); end
  endtask

  // Pointer sits at 3 here, so the rotation starts at port 3.
  task automatic test_round_robin();
    logic [1:0] exp_port;
    logic [3:0] exp_grant;
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      exp_port  = 2'(3 + c);
      exp_grant = 4'b0001 << exp_port;
      #1;
      n_checks++; if (req_grant !== exp_grant) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_grant, exp_grant); end
      @(posedge clk); #1;
      n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b expected 1", c, issue_valid); end
      n_checks++; if (issue_info !== info[exp_port]) begin n_fail++; $display("FAIL rr_info[%0d]: got %h expected %h", c, issue_info, info[exp_port]); end
    end
    n_checks++; if (issue_count !== 16'd7) begin n_fail++; $display("FAIL rr_count: got %0d expected 7", issue_count); end
  endtask

  task automatic test_backpressure();
    alu_ready = 1'b0;
    req_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL bp_grant[%0d]: got %b expected 0000", c, req_grant); end
      @(posedge clk); #1;
      n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, issue_valid); end
      n_checks++; if (issue_info !== info[0]) begin n_fail++; $display("FAIL bp_info[%0d]: got %h expected %h", c, issue_info, info[0]); end
    end
    alu_ready = 1'b1;
    #1;
    n_checks++; if (req_grant !== 4'b0010) begin n_fail++; $display("FAIL bp_release_grant: got %b expected 0010", req_grant); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    n_checks++; if (issue_info !== info[1]) begin n_fail++; $display("FAIL bp_reload_info: got %h expected %h", issue_info, info[1]); end
    n_checks++; if (issue_count !== 16'd8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", issue_count); end
  endtask

  task automatic test_flush();
    req_valid = 4'b1000;
    flush = 1'b1;
    #1;
    n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL flush_grant: got %b expected 0000", req_grant); end
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", issue_valid); end
    n_checks++; if (issue_count !== 16'd8) begin n_fail++; $display("FAIL flush_count: got %0d expected 8", issue_count); end
    n_checks++; if (u_dut.r_rr_ptr !== 2'd2) begin n_fail++; $display("FAIL flush_ptr: got %0d expected 2", u_dut.r_rr_ptr); end
    #1;
    n_checks++; if (req_grant !== 4'b1000) begin n_fail++; $display("FAIL post_flush_grant: got %b expected 1000", req_grant); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL post_flush_valid: got %b expected 1", issue_valid); end
    n_checks++; if (issue_info !== info[3]) begin n_fail++; $display("FAIL post_flush_info: got %h expected %h", issue_info, info[3]); end
    n_checks++; if (issue_count !== 16'd9) begin n_fail++; $display("FAIL post_flush_count: got %0d expected 9", issue_count); end
  endtask

  task automatic test_wrap_withdraw();
    req_valid = 4'b0100;
    @(posedge clk); #1;
    n_checks++; if (u_dut.r_rr_ptr !== 2'd3) begin n_fail++; $display("FAIL wrap_setup_ptr: got %0d expected 3", u_dut.r_rr_ptr); end
    req_valid = 4'b1001;
    #1;
    n_checks++; if (req_grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_grant: got %b expected 1000", req_grant); end
    @(posedge clk); #1;
    n_checks++; if (u_dut.r_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL wrap_ptr: got %0d expected 0", u_dut.r_rr_ptr); end
    n_checks++; if (issue_info !== info[3]) begin n_fail++; $display("FAIL wrap_info: got %h expected %h", issue_info, info[3]); end
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_grant !== 4'b0010) begin n_fail++; $display("FAIL withdraw_grant: got %b expected 0010", req_grant); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    n_checks++; if (u_dut.r_rr_ptr !== 2'd2) begin n_fail++; $display("FAIL withdraw_ptr: got %0d expected 2", u_dut.r_rr_ptr); end
    n_checks++; if (issue_info !== info[1]) begin n_fail++; $display("FAIL withdraw_info: got %h expected %h", issue_info, info[1]); end
    n_checks++; if (issue_count !== 16'd12) begin n_fail++; $display("FAIL withdraw_count: got %0d expected 12", issue_count); end
  endtask

  task automatic test_async_reset();
    n_checks++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b expected 1", issue_valid); end
    req_valid = 4'b1111;
    #3;
    rst = 1'b0;
    #1;
    n_checks++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", issue_valid); end
    n_checks++; if (issue_count !== 16'd0) begin n_fail++; $display("FAIL areset_count: got %0d expected 0", issue_count); end
    n_checks++; if (u_dut.r_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL areset_ptr: got %0d expected 0", u_dut.r_rr_ptr); end
    n_checks++; if (req_grant !== 4'b0000) begin n_fail++; $display("FAIL areset_grant: got %b expected 0000", req_grant); end
    #2;
    rst = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_counter_wrap();
    req_valid4 = 4'b0001;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); #1;
      if (c == 15) begin
        n_checks++; if (issue_count4 !== 4'd15) begin n_fail++; $display("FAIL cnt_max: got %0d expected 15", issue_count4); end
      end
      if (c == 16) begin
        n_checks++; if (issue_count4 !== 4'd0) begin n_fail++; $display("FAIL cnt_wrap: got %0d expected 0", issue_count4); end
      end
    end
    req_valid4 = 4'b0000;
    n_checks++; if (issue_count4 !== 4'd1) begin n_fail++; $display("FAIL cnt_after_17: got %0d expected 1", issue_count4); end
    n_checks++; if (issue_info4 !== 32'h4444_0000) begin n_fail++; $display("FAIL cnt_info: got %h expected 44440000", issue_info4); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_wrap_withdraw();
    test_async_reset();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
